arrival_barrier: RTL

- Parametrised N-channel arrival barrier, the successor to the fixed 4-entrant "all men in" detector.
- Each enabled channel latches a sticky arrival bit. When every enabled channel has arrived, the block flags completion. It adds per-channel enables, an arrival count, a collection timeout with a missing-channel report, and a selectable auto-clear or acknowledge-clear mode.
- Used as a rendezvous/occupancy checker between request sources and downstream control.

---
 rtl/arrival_barrier_pkg.sv | 16 +
 rtl/arrival_barrier_popcount_n.sv | 20 ++
 rtl/arrival_barrier.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arrival_barrier_pkg.sv
// Shared definitions for the arrival barrier: state encoding and width helper.
package arrival_barrier_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2,
    StTimeout = 2'd3
  } state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned bits_for(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arrival_barrier_popcount_n.sv
// Combinational ones counter over an N-bit vector.
module popcount_n
  import arrival_barrier_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = bits_for(N)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] ones
);

  // Sum the set bits.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + W'(bits[i]);
    end
  end

endmodule

// File: rtl/arrival_barrier.sv
// N-channel arrival barrier: latches sticky per-channel arrivals, flags completion
// when every enabled channel is in, and reports missing channels on timeout.
module arrival_barrier
  import arrival_barrier_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TIMEOUT    = 8,
  parameter bit          AUTO_CLEAR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_in,
  input  logic [N_CH-1:0]           arrive,
  input  logic [N_CH-1:0]           ch_en,
  input  logic                      clear,
  input  logic                      ack,
  output logic [N_CH-1:0]           arrived,
  output logic [bits_for(N_CH)-1:0] count,
  output logic                      all_in,
  output logic                      timeout,
  output logic [N_CH-1:0]           missing,
  output logic                      busy
);

  localparam int unsigned CntW      = bits_for(N_CH);
  localparam int unsigned TimerW    = bits_for(TIMEOUT);
  localparam int unsigned TimerLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   arrived_q, arrived_d;
  logic [N_CH-1:0]   missing_q, missing_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [N_CH-1:0]   arr_in;
  logic [N_CH-1:0]   arrived_lat;
  logic              cmp;

  // Count follows the next-state arrival mask so it updates on the same edge.
  popcount_n #(
    .N(N_CH),
    .W(CntW)
  ) u_popcount (
    .bits(arrived_d),
    .ones(count_d)
  );

  // Next-state logic; clear overrides every state.
  always_comb begin
    arr_in      = arrive & ch_en;
    arrived_lat = arrived_q | arr_in;
    // ch_en is live, so dropping a missing channel can complete the set.
    cmp         = (ch_en != '0) && ((arrived_lat & ch_en) == ch_en);

    state_d   = state_q;
    arrived_d = arrived_q;
    missing_d = missing_q;
    timer_d   = timer_q;

    if (clear) begin
      state_d   = StIdle;
      arrived_d = '0;
      missing_d = '0;
      timer_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          arrived_d = arrived_lat;
          if (arr_in != '0) begin
            timer_d = '0;
            state_d = cmp ? StDone : StCollect;
          end
        end
        StCollect: begin
          arrived_d = arrived_lat;
          if (TIMEOUT != 0) timer_d = timer_q + TimerW'(1);
          // Completion takes precedence over a coincident timeout.
          if (cmp) begin
            state_d = StDone;
          end else if ((TIMEOUT != 0) && (timer_q == TimerW'(TimerLast))) begin
            state_d   = StTimeout;
            missing_d = ch_en & ~arrived_lat;
          end
        end
        StDone: begin
          if (AUTO_CLEAR || ack) begin
            state_d   = StIdle;
            arrived_d = '0;
          end
        end
        StTimeout: begin
          if (ack) begin
            state_d   = StIdle;
            arrived_d = '0;
            missing_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      arrived_q <= '0;
      missing_q <= '0;
      timer_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      missing_q <= missing_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    arrived = arrived_q;
    count   = count_q;
    missing = missing_q;
    all_in  = (state_q == StDone);
    timeout = (state_q == StTimeout);
    busy    = (state_q == StCollect);
  end

endmodule
